// File: rtl/bbc_keyboard_matrix_pkg.sv
// Shared constants and types for the BBC Micro keyboard matrix emulation.
package bbc_keyboard_matrix_pkg;

  localparam int unsigned KB_ROWS       = 8;
  localparam int unsigned KB_COLS       = 10;
  localparam int unsigned LINK_BASE_COL = 2;
  // Full 4-bit column address space seen by the counter and by PA[3:0]
  localparam int unsigned ADDR_COLS     = 16;

  typedef enum logic {
    MODE_MANUAL   = 1'b0,
    MODE_AUTOSCAN = 1'b1
  } kb_mode_e;

  typedef logic [ADDR_COLS-1:0] kb_row_t;

  // One bit per addressable column, set for columns below n
  function automatic kb_row_t col_mask(int unsigned n);
    kb_row_t m;
    m = '0;
    for (int unsigned i = 0; i < ADDR_COLS; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/bbc_keyboard_matrix_if.sv
// Key event bus from the PS/2 decoder into the keyboard matrix.
interface bbc_keyboard_matrix_if;
  logic       KEY_VALID;
  logic       KEY_MAKE;
  logic [2:0] KEY_ROW;
  logic [3:0] KEY_COL;
  logic       ALL_UP;

  modport master (
    output KEY_VALID, KEY_MAKE, KEY_ROW, KEY_COL, ALL_UP
  );

  modport slave (
    input KEY_VALID, KEY_MAKE, KEY_ROW, KEY_COL, ALL_UP
  );
endinterface

// File: rtl/bbc_kb_column_counter.sv
// 4-bit synchronous load/count column counter modelled on the 74LS163.
module bbc_kb_column_counter (
  input  logic       clk,
  input  logic       RESET,
  input  logic       clk_en,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] count
);

  // Load or free-wrapping increment, only on bus-cycle enable
  always_ff @(posedge clk) begin
    if (RESET) begin
      count <= '0;
    end else if (clk_en) begin
      if (load) begin
        count <= load_val;
      end else begin
        count <= count + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bbc_keyboard_matrix.sv
// BBC Micro keyboard matrix: key state array, autoscan CA2 and PA7 readback.
module bbc_keyboard_matrix
  import bbc_keyboard_matrix_pkg::*;
#(
  parameter logic [7:0]  DIP_LINKS = 8'h00,
  parameter int unsigned NUM_COLS  = 10
) (
  input  logic                        clk,
  input  logic                        RESET,
  input  logic                        clk_en,
  input  logic                        nKBEN,
  input  logic [6:0]                  PA_IN,
  output logic                        PA7_OUT,
  output logic                        CA2_OUT,
  bbc_keyboard_matrix_if.slave        key_bus,
  output logic [3:0]                  COL_CNT
);

  localparam kb_row_t POP_MASK  = col_mask(NUM_COLS);
  localparam kb_row_t LINK_MASK = kb_row_t'(DIP_LINKS) << LINK_BASE_COL;

  logic [KB_ROWS-1:0][KB_COLS-1:0] keys;
  kb_row_t                         eff [KB_ROWS];
  kb_mode_e                        mode;
  logic                            scan_hit;
  logic                            event_ok;

  assign mode     = kb_mode_e'(nKBEN);
  assign event_ok = key_bus.KEY_VALID && (32'(key_bus.KEY_COL) < NUM_COLS);

  // Key array: reset and ALL_UP clear everything; otherwise apply one event
  always_ff @(posedge clk) begin
    if (RESET || key_bus.ALL_UP) begin
      keys <= '0;
    end else if (event_ok) begin
      for (int unsigned r = 0; r < KB_ROWS; r++) begin
        for (int unsigned c = 0; c < KB_COLS; c++) begin
          if (key_bus.KEY_ROW == 3'(r) && key_bus.KEY_COL == 4'(c)) begin
            keys[r][c] <= key_bus.KEY_MAKE;
          end
        end
      end
    end
  end

  // Effective matrix over the full 16-column address space; unpopulated
  // columns read empty, row 0 additionally carries the startup links
  always_comb begin
    for (int unsigned r = 0; r < KB_ROWS; r++) begin
      eff[r] = kb_row_t'(keys[r]) & POP_MASK;
    end
    eff[0] = eff[0] | (LINK_MASK & POP_MASK);
  end

  // Any key in rows 1-7 of the column currently on the counter
  always_comb begin
    scan_hit = 1'b0;
    for (int unsigned r = 1; r < KB_ROWS; r++) begin
      scan_hit = scan_hit | eff[r][COL_CNT];
    end
  end

  // Autoscan interrupt, sampled against the pre-update column each bus cycle
  always_ff @(posedge clk) begin
    if (RESET) begin
      CA2_OUT <= 1'b0;
    end else if (clk_en) begin
      CA2_OUT <= scan_hit;
    end
  end

  assign PA7_OUT = !RESET && (mode == MODE_MANUAL) && eff[PA_IN[6:4]][PA_IN[3:0]];

  bbc_kb_column_counter u_col_cnt (
    .clk      (clk),
    .RESET    (RESET),
    .clk_en   (clk_en),
    .load     (mode == MODE_MANUAL),
    .load_val (PA_IN[3:0]),
    .count    (COL_CNT)
  );

endmodule
